adder_4bit_behav: RTL and testbench

Registered 4-bit binary adder with carry-in and carry-out, used as the basic arithmetic building block in datapaths that need one cycle of latency. It takes two unsigned operands and a carry-in, forms the full sum combinationally, and captures the result in output registers on the next rising clock edge. A valid strobe travels alongside the data, so upstream and downstream logic can tell new results from held ones.

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder_1bit.sv | 19 +
 rtl/adder_4bit_behav.sv | 76 +++++++
 tb/tb_adder_4bit_behav.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the registered 4-bit adder.
//   ADDER_WIDTH : operand/sum width (fixed at 4)
//   operand_t   : unsigned 4-bit operand
//   result_t    : 5-bit {carry, sum} result
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 4;

  typedef logic [ADDER_WIDTH-1:0] operand_t;
  typedef logic [ADDER_WIDTH:0]   result_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder, one stage of the ripple chain.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/adder_4bit_behav.sv
// Registered 4-bit adder with carry-in/carry-out and a valid strobe.
// Result registers load only when in_valid is high; out_valid follows in_valid every edge.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   a, b      : unsigned operands
//   carry_in  : carry into bit 0
//   in_valid  : operands valid this cycle
//   sum       : registered sum
//   carry_out : registered carry out of the MSB
//   out_valid : registered copy of in_valid
//   overflow  : registered signed overflow (only with ADDER_4BIT_OVERFLOW_EN defined)
module adder_4bit_behav
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
`ifdef ADDER_4BIT_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  result_t          res;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1bit u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign res = {c[WIDTH], s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= res[WIDTH-1:0];
        carry_out <= res[WIDTH];
      end
    end
  end

`ifdef ADDER_4BIT_OVERFLOW_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= c[WIDTH-1] ^ c[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_adder_4bit_behav.sv
// Self-checking bench for adder_4bit_behav: directed steps plus random traffic,
// compared against an arithmetic reference model.
module tb_adder_4bit_behav;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       carry_in = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] sum;
  logic       carry_out;
  logic       out_valid;
`ifdef ADDER_4BIT_OVERFLOW_EN
  logic       overflow;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  int exp_sum = 0;
  int exp_co  = 0;
  int exp_ov  = 0;
  int exp_vld = 0;

  adder_4bit_behav dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .in_valid (in_valid),
    .sum      (sum),
    .carry_out(carry_out),
    .out_valid(out_valid)
`ifdef ADDER_4BIT_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sum"}, int'(sum), exp_sum);
    check({tag, ".carry_out"}, int'(carry_out), exp_co);
    check({tag, ".out_valid"}, int'(out_valid), exp_vld);
`ifdef ADDER_4BIT_OVERFLOW_EN
    check({tag, ".overflow"}, int'(overflow), exp_ov);
`endif
  endtask

  task automatic model_reset();
    exp_sum = 0;
    exp_co  = 0;
    exp_ov  = 0;
    exp_vld = 0;
  endtask

  // Plain-arithmetic model of one clock edge.
  task automatic model_edge(input int ma, input int mb, input int mc, input int mv);
    int total;
    int sa;
    int sb;
    int st;
    if (rst) begin
      model_reset();
      return;
    end
    exp_vld = mv;
    if (mv != 0) begin
      total   = ma + mb + mc;
      exp_sum = total % 16;
      exp_co  = total / 16;
      sa      = (ma >= 8) ? ma - 16 : ma;
      sb      = (mb >= 8) ? mb - 16 : mb;
      st      = sa + sb + mc;
      exp_ov  = (st > 7 || st < -8) ? 1 : 0;
    end
  endtask

  // Drive on the falling edge, update model at the rising edge, sample 1 time unit later.
  task automatic step(input int sa, input int sb, input int sc, input int sv,
                      input string tag);
    @(negedge clk);
    a        = sa[3:0];
    b        = sb[3:0];
    carry_in = sc[0];
    in_valid = sv[0];
    @(posedge clk);
    model_edge(sa, sb, sc, sv);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // Reset with no clock running
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset_noclk");

    clk_en = 1'b1;
    #10;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "post_reset_idle");

    // Sweep: a and b counting down 4..1, carry_in = a % 2
    for (int i = 4; i >= 1; i--) begin
      for (int j = 4; j >= 1; j--) step(i, j, i % 2, 1, "sweep");
    end
    step(4, 4, 0, 1, "sweep_4_4_0");
    check("sweep_4_4_0.const", int'(sum), 8);
    step(3, 2, 1, 1, "sweep_3_2_1");
    check("sweep_3_2_1.const", int'(sum), 6);
    step(1, 1, 1, 1, "sweep_1_1_1");
    check("sweep_1_1_1.const", int'(sum), 3);

    // Carry and wrap corners
    step(15, 1, 0, 1, "wrap_15_1_0");
    check("wrap_15_1_0.const", int'({carry_out, sum}), 16);
    step(15, 15, 1, 1, "max_15_15_1");
    check("max_15_15_1.const", int'({carry_out, sum}), 31);
    step(0, 0, 0, 1, "zero");
    check("zero.const", int'({carry_out, sum}), 0);
    step(15, 0, 1, 1, "wrap_15_0_1");
    check("wrap_15_0_1.const", int'({carry_out, sum}), 16);

    // Hold when in_valid is low
    step(5, 6, 0, 1, "hold_load");
    step(9, 9, 1, 0, "hold_idle");
    check("hold_idle.const", int'(sum), 11);

    // Reset between edges discards the loaded result
    step(7, 7, 1, 1, "pre_reset_load");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    step(2, 3, 0, 1, "after_reset");
    check("after_reset.const", int'(sum), 5);

    // Reset wins over in_valid on the same edge
    @(negedge clk);
    rst = 1'b1;
    step(9, 4, 1, 1, "reset_wins");
    @(negedge clk);
    rst = 1'b0;

`ifdef ADDER_4BIT_OVERFLOW_EN
    step(7, 1, 0, 1, "ov_7_1");
    check("ov_7_1.const", int'(overflow), 1);
    step(8, 8, 0, 1, "ov_8_8");
    check("ov_8_8.const", int'(overflow), 1);
    step(3, 2, 0, 1, "ov_3_2");
    check("ov_3_2.const", int'(overflow), 0);
`endif

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      step(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)),
           ($urandom_range(3) != 0) ? 1 : 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
